// File: rtl/slave_cpl_tracker.sv
// rtl/slave_cpl_tracker.sv - completion tracker: recorder lookup, entry update/retire, tag free, AXI response
module slave_cpl_tracker #(
    parameter int TAG_W   = 5,
    parameter int ID_W    = 4,
    parameter int BC_W    = 13,
    parameter int LA_W    = 7,
    parameter int ENTRY_W = 1 + ID_W + BC_W + LA_W
) (
    input  logic               clk,
    input  logic               ARESTn,
    input  logic               cpl_valid,
    output logic               cpl_ready,
    input  logic [TAG_W-1:0]   cpl_tag,
    input  logic [BC_W-1:0]    cpl_byte_count,
    input  logic [BC_W-1:0]    cpl_len_bytes,
    input  logic [2:0]         cpl_status,
    output logic [TAG_W-1:0]   resp_rd_addr,
    input  logic [ENTRY_W-1:0] resp_rd_data,
    output logic               resp_wr_en,
    output logic [TAG_W-1:0]   resp_wr_addr,
    output logic [ENTRY_W-1:0] resp_wr_data,
    output logic               tag_free_valid,
    output logic [TAG_W-1:0]   tag_free,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic [1:0]         res_resp,
    output logic               res_last,
    output logic               res_unexp
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t               r_state;
    state_t               w_next_state;

    logic [TAG_W-1:0]     r_tag;
    logic [BC_W-1:0]      r_bc;
    logic [BC_W-1:0]      r_len;
    logic [2:0]           r_status;

    logic                 r_do_write;
    logic                 r_do_free;
    logic [ENTRY_W-1:0]   r_wr_data;
    logic [ID_W-1:0]      r_res_id;
    logic [1:0]           r_res_resp;
    logic                 r_res_last;
    logic                 r_res_unexp;

    // Recorder entry fields, MSB first: {valid, id, remaining, lower_addr}
    logic                 w_ent_valid;
    logic [ID_W-1:0]      w_ent_id;
    logic [BC_W-1:0]      w_ent_rem;
    logic [LA_W-1:0]      w_ent_la;

    logic                 w_do_write;
    logic                 w_do_free;
    logic [ENTRY_W-1:0]   w_wr_data;
    logic [ID_W-1:0]      w_res_id;
    logic [1:0]           w_res_resp;
    logic                 w_res_last;
    logic                 w_res_unexp;

    logic                 w_accept;

    assign w_ent_valid = resp_rd_data[ENTRY_W-1];
    assign w_ent_id    = resp_rd_data[ENTRY_W-2 -: ID_W];
    assign w_ent_rem   = resp_rd_data[LA_W +: BC_W];
    assign w_ent_la    = resp_rd_data[LA_W-1:0];

    assign w_accept    = (r_state == S_IDLE) && cpl_valid;

    // State register
    always_ff @(posedge clk or negedge ARESTn) begin
        if (!ARESTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed LOOKUP/WRITE pass, RESP holds until the response handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (cpl_valid) w_next_state = S_LOOKUP;
            S_LOOKUP: w_next_state = S_WRITE;
            S_WRITE:  w_next_state = S_RESP;
            S_RESP:   if (res_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Completion decision from the looked-up entry; unexpected beats error beats final beats partial
    always_comb begin
        w_do_write  = 1'b0;
        w_do_free   = 1'b0;
        w_wr_data   = resp_rd_data;
        w_res_id    = w_ent_id;
        w_res_resp  = RESP_OKAY;
        w_res_last  = 1'b0;
        w_res_unexp = 1'b0;
        if (!w_ent_valid) begin
            w_res_id    = '0;
            w_res_resp  = RESP_SLVERR;
            w_res_last  = 1'b1;
            w_res_unexp = 1'b1;
        end else if ((r_status != 3'b000) || (r_bc != w_ent_rem)) begin
            w_do_write  = 1'b1;
            w_do_free   = 1'b1;
            w_wr_data   = {1'b0, w_ent_id, w_ent_rem, w_ent_la};
            w_res_resp  = RESP_SLVERR;
            w_res_last  = 1'b1;
        end else if (r_len >= w_ent_rem) begin
            w_do_write  = 1'b1;
            w_do_free   = 1'b1;
            w_wr_data   = {1'b0, w_ent_id, {BC_W{1'b0}}, w_ent_la};
            w_res_last  = 1'b1;
        end else begin
            // Lower address wraps naturally at LA_W bits
            w_do_write  = 1'b1;
            w_wr_data   = {1'b1, w_ent_id, w_ent_rem - r_len, w_ent_la + r_len[LA_W-1:0]};
        end
    end

    // Latch the accepted header, then the decision made during LOOKUP
    always_ff @(posedge clk or negedge ARESTn) begin
        if (!ARESTn) begin
            r_tag       <= '0;
            r_bc        <= '0;
            r_len       <= '0;
            r_status    <= '0;
            r_do_write  <= 1'b0;
            r_do_free   <= 1'b0;
            r_wr_data   <= '0;
            r_res_id    <= '0;
            r_res_resp  <= '0;
            r_res_last  <= 1'b0;
            r_res_unexp <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag    <= cpl_tag;
                r_bc     <= cpl_byte_count;
                r_len    <= cpl_len_bytes;
                r_status <= cpl_status;
            end
            if (r_state == S_LOOKUP) begin
                r_do_write  <= w_do_write;
                r_do_free   <= w_do_free;
                r_wr_data   <= w_wr_data;
                r_res_id    <= w_res_id;
                r_res_resp  <= w_res_resp;
                r_res_last  <= w_res_last;
                r_res_unexp <= w_res_unexp;
            end
        end
    end

    // Outputs decoded from state; the free shares the write cycle so a tag is never re-issued before retirement
    always_comb begin
        cpl_ready      = 1'b0;
        resp_rd_addr   = '0;
        resp_wr_en     = 1'b0;
        resp_wr_addr   = '0;
        resp_wr_data   = '0;
        tag_free_valid = 1'b0;
        tag_free       = '0;
        res_valid      = 1'b0;
        res_id         = '0;
        res_resp       = '0;
        res_last       = 1'b0;
        res_unexp      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpl_ready = ARESTn;
            end
            S_LOOKUP: begin
                resp_rd_addr = r_tag;
            end
            S_WRITE: begin
                if (r_do_write) begin
                    resp_wr_en   = 1'b1;
                    resp_wr_addr = r_tag;
                    resp_wr_data = r_wr_data;
                end
                if (r_do_free) begin
                    tag_free_valid = 1'b1;
                    tag_free       = r_tag;
                end
            end
            S_RESP: begin
                res_valid = 1'b1;
                res_id    = r_res_id;
                res_resp  = r_res_resp;
                res_last  = r_res_last;
                res_unexp = r_res_unexp;
            end
            default: begin
                cpl_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/slave_cpl_tracker.md
Name: slave_cpl_tracker

Overview:
Response-side consumer of the slave bridge request recorder. It accepts completion headers from the RX completion path and looks up the recorded request by tag through the recorder's response port. It then updates or retires the entry, returns the freed tag to the tag allocator and presents the per-completion AXI response to the R/B response path.

Parameters:
TAG_W, 5, tag/recorder address width (recorder depth 2**TAG_W)
ID_W, 4, AXI ID width stored in entry
BC_W, 13, remaining byte-count width (value 4096 is representable)
LA_W, 7, lower-address field width
ENTRY_W, 1+ID_W+BC_W+LA_W (=25), recorder entry width

Ports:
clk  in  1  clock
ARESTn  in  1  asynchronous active-low reset
cpl_valid  in  1  completion header valid
cpl_ready  out  1  tracker can accept header
cpl_tag  in  TAG_W  completion tag (recorder address)
cpl_byte_count  in  BC_W  header byte count; already decoded, 0 is never presented (4096 is given as 4096)
cpl_len_bytes  in  BC_W  payload bytes carried by this completion
cpl_status  in  3  completion status; 3'b000 = SC
resp_rd_addr  out  TAG_W  recorder response-port read address (async read)
resp_rd_data  in  ENTRY_W  recorder entry {valid, id, remaining, lower_addr}, MSB first
resp_wr_en  out  1  recorder write strobe
resp_wr_addr  out  TAG_W  recorder write address
resp_wr_data  out  ENTRY_W  recorder write data
tag_free_valid  out  1  one-cycle pulse; the tag is returned to the allocator
tag_free  out  TAG_W  tag being freed
res_valid  out  1  AXI response info valid
res_ready  in  1  response path accepts
res_id  out  ID_W  AXI ID from entry
res_resp  out  2  2'b00 OKAY, 2'b10 SLVERR
res_last  out  1  final completion for the request
res_unexp  out  1  tag not valid in recorder (unexpected completion)

Behaviour:
- Reset (async, ARESTn=0): state IDLE; all outputs 0 except cpl_ready=1 once ARESTn=1. Internal latches are cleared. Reset during any state aborts without a write or free.
- FSM states: IDLE, LOOKUP, WRITE, RESP.
- IDLE: cpl_ready=1. On cpl_valid&cpl_ready, latch tag/byte_count/len/status and go to LOOKUP. cpl_ready=0 in all other states.
- LOOKUP (1 cycle): resp_rd_addr=latched tag. Capture resp_rd_data into an entry register and compute the decision below. Next state is WRITE.
- Decision, in priority order:
  1. Entry valid=0: unexpected. res_unexp=1, res_resp=10, res_last=1, res_id=0. No recorder write, no tag free.
  2. cpl_status!=000 or cpl_byte_count!=stored remaining: error. Write entry with valid=0 (other fields unchanged), free tag, res_resp=10, res_last=1.
  3. cpl_len_bytes>=stored remaining: final. Write valid=0, remaining=0, free tag, res_resp=00, res_last=1.
  4. Otherwise: partial. Write valid=1, remaining=stored-len (BC_W-bit subtract, no underflow possible by rule 3), lower_addr=(lower_addr+len) mod 2**LA_W. No free; res_resp=00, res_last=0.
- WRITE (1 cycle): resp_wr_en=1 with resp_wr_addr=tag when the decision requires a write. tag_free_valid=1 with tag_free=tag when the decision frees the tag. Next state is RESP.
- RESP: res_valid=1 with res_id/res_resp/res_last/res_unexp held stable until res_ready. On res_valid&res_ready go to IDLE; res_valid drops in the next cycle.
- Throughput: 4 cycles per completion with res_ready held high (accept, LOOKUP, WRITE, RESP).
- Free only after write: a tag is freed in the same cycle as its invalidating write, so the allocator cannot re-issue it before retirement. A recorder write-port collision on the same address therefore cannot occur for a live tag.
- res_* outputs are 0 when res_valid=0.

Test Plan:
1. Reset mid-op: assert ARESTn=0 while in WRITE with a pending write -> resp_wr_en=0, tag_free_valid=0, res_valid=0; after release cpl_ready=1.
2. Single completion: entry[3]={1,id=5,rem=64,la=0}, cpl tag=3, bc=64, len=64, SC -> WRITE writes {0,5,0,0} to addr 3; tag_free_valid pulse with tag_free=3; res_id=5, res_resp=00, res_last=1.
3. Split completion: entry[7]={1,2,128,0x10}; cpl1 bc=128, len=64 -> write {1,2,64,0x50}, no free, res_last=0; cpl2 bc=64, len=64 -> invalidate, free 7, res_last=1.
4. Error status: entry[1] valid, cpl_status=3'b001 -> entry invalidated, tag 1 freed, res_resp=10, res_last=1.
5. Unexpected: entry[9] valid=0, cpl tag=9 -> no resp_wr_en, no free, res_unexp=1, res_resp=10.
6. Backpressure: hold res_ready=0 for 5 cycles -> res_valid and its fields stay stable and cpl_ready=0 for the whole wait; accept resumes in the cycle after the handshake. Also byte-count mismatch (bc=32 vs stored 64) -> res_resp=10, tag freed.
